// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: block-type codes, board geometry defaults and the
// falling-piece descriptor with its 4x4 box hit test.
package tetris_pkg;

  typedef enum logic [2:0] {
    NOBLOCK = 3'd0,
    CYAN    = 3'd1,
    BLUE    = 3'd2,
    YELLOW  = 3'd3,
    GREEN   = 3'd4,
    PURPLE  = 3'd5,
    RED     = 3'd6,
    ORANGE  = 3'd7
  } blk_t;

  localparam int DEF_ORIGIN_X = 220;
  localparam int DEF_ORIGIN_Y = 40;
  localparam int DEF_CELL     = 20;
  localparam int DEF_COLS     = 10;
  localparam int DEF_ROWS     = 20;

  localparam int BOARD_ADDR_W = 8;
  localparam int COORD_W      = 10;
  localparam int BLK_W        = 3;

  typedef struct packed {
    logic signed [4:0] col;
    logic signed [5:0] row;
    logic [15:0]       mask;
    logic [2:0]        ptype;
  } piece_t;

  // Offsets are formed modulo 128; a value in 0..3 has its upper five bits clear,
  // which rejects negative offsets without a signed compare.
  function automatic logic piece_hit(input logic [6:0] row, input logic [6:0] col,
                                     input piece_t pc);
    logic [6:0] pr;
    logic [6:0] pcd;
    pr  = row - {pc.row[5], pc.row};
    pcd = col - {{2{pc.col[4]}}, pc.col};
    if ((pr[6:2] == 5'd0) && (pcd[6:2] == 5'd0)) begin
      piece_hit = pc.mask[{pr[1:0], pcd[1:0]}];
    end else begin
      piece_hit = 1'b0;
    end
  endfunction

endpackage

// File: rtl/playfield_scanner_if.sv
// Pixel stream, falling-piece state and board-RAM port between the video/game
// logic (master) and playfield_scanner (slave).
interface playfield_scanner_if;
  import tetris_pkg::*;

  logic                    pix_en;
  logic [COORD_W-1:0]      x;
  logic [COORD_W-1:0]      y;
  logic                    active_in;
  logic                    hsync_in;
  logic                    vsync_in;
  logic signed [4:0]       piece_col;
  logic signed [5:0]       piece_row;
  logic [15:0]             piece_mask;
  logic [BLK_W-1:0]        piece_type;
  logic [BOARD_ADDR_W-1:0] board_addr;
  logic [BLK_W-1:0]        board_data;
  logic [BLK_W-1:0]        blktype;
  logic                    in_field;
  logic                    cell_edge;
  logic                    active_out;
  logic                    hsync_out;
  logic                    vsync_out;

  modport master (
    output pix_en, x, y, active_in, hsync_in, vsync_in,
    output piece_col, piece_row, piece_mask, piece_type, board_data,
    input  board_addr, blktype, in_field, cell_edge, active_out, hsync_out, vsync_out
  );

  modport slave (
    input  pix_en, x, y, active_in, hsync_in, vsync_in,
    input  piece_col, piece_row, piece_mask, piece_type, board_data,
    output board_addr, blktype, in_field, cell_edge, active_out, hsync_out, vsync_out
  );

endinterface

// File: rtl/pix_delay.sv
// N-deep, W-wide enabled shift register with a per-bit reset value; every stage
// is exposed so callers can tap intermediate alignment points.
module pix_delay #(
  parameter int            N         = 2,
  parameter int            W         = 1,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic [W-1:0]        din_i,
  output logic [N-1:0][W-1:0] taps_o
);

  logic [N-1:0][W-1:0] pipe_q;

  // Shift one stage per enabled pixel; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= {N{RESET_VAL}};
    end else if (en_i) begin
      pipe_q[0] <= din_i;
      for (int i = 1; i < N; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign taps_o = pipe_q;

endmodule

// File: rtl/playfield_scanner.sv
// Pixel-rate playfield scan: counter-based cell addressing, board RAM fetch and
// falling-piece overlay, with sync/flags delayed to stay aligned with blktype.
module playfield_scanner
  import tetris_pkg::*;
#(
  parameter int ORIGIN_X = DEF_ORIGIN_X,
  parameter int ORIGIN_Y = DEF_ORIGIN_Y,
  parameter int CELL     = DEF_CELL,
  parameter int COLS     = DEF_COLS,
  parameter int ROWS     = DEF_ROWS
) (
  input logic                clk,
  input logic                rst_n,
  playfield_scanner_if.slave bus
);

  localparam int SUB_W = $clog2(CELL);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  localparam logic [COORD_W-1:0]      X_LO     = COORD_W'(ORIGIN_X);
  localparam logic [COORD_W-1:0]      X_HI     = COORD_W'(ORIGIN_X + COLS * CELL);
  localparam logic [COORD_W-1:0]      Y_LO     = COORD_W'(ORIGIN_Y);
  localparam logic [COORD_W-1:0]      Y_HI     = COORD_W'(ORIGIN_Y + ROWS * CELL);
  localparam logic [SUB_W-1:0]        SUB_LAST = SUB_W'(CELL - 1);
  localparam logic [BOARD_ADDR_W-1:0] ROW_STEP = BOARD_ADDR_W'(COLS);

  // Delay-line bit layout; syncs idle high.
  localparam int             DL_W   = 5;
  localparam int             DL_ACT = 4;
  localparam int             DL_HS  = 3;
  localparam int             DL_VS  = 2;
  localparam int             DL_IF  = 1;
  localparam int             DL_CE  = 0;
  localparam logic [DL_W-1:0] DL_RST = 5'b01100;

  logic [SUB_W-1:0]        subx_q, subx_d;
  logic [SUB_W-1:0]        suby_q, suby_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [BOARD_ADDR_W-1:0] row_base_q, row_base_d;
  logic [BOARD_ADDR_W-1:0] board_addr_q, board_addr_d;
  logic                    vsync_prev_q;
  piece_t                  piece_q, piece_d;
  logic [BLK_W-1:0]        blktype_q, blktype_d;

  logic                    in_field_s;
  logic                    cell_edge_s;
  logic                    vsync_fall_s;
  logic                    hit_s;
  logic [DL_W-1:0]         dl_in_s;
  logic [1:0][DL_W-1:0]    dl_taps_s;
  logic                    unused_taps_s;

  // Horizontal cell tracking: restart at the field's left edge, wrap every CELL pixels.
  always_comb begin
    subx_d = subx_q;
    col_d  = col_q;
    if (bus.x == X_LO) begin
      subx_d = '0;
      col_d  = '0;
    end else if (subx_q == SUB_LAST) begin
      subx_d = '0;
      col_d  = col_q + COL_W'(1);
    end else begin
      subx_d = subx_q + SUB_W'(1);
    end
  end

  // Vertical cell tracking: advances once per line on x==0, restarts on the first field line.
  always_comb begin
    suby_d     = suby_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    if (bus.x == '0) begin
      if (bus.y == Y_LO) begin
        suby_d     = '0;
        row_d      = '0;
        row_base_d = '0;
      end else if (suby_q == SUB_LAST) begin
        suby_d     = '0;
        row_d      = row_q + ROW_W'(1);
        row_base_d = row_base_q + ROW_STEP;
      end else begin
        suby_d = suby_q + SUB_W'(1);
      end
    end else begin
      suby_d     = suby_q;
      row_d      = row_q;
      row_base_d = row_base_q;
    end
  end

  // Field window comes straight from x/y so stale counters can never fake it.
  always_comb begin
    in_field_s   = (bus.x >= X_LO) && (bus.x < X_HI) && (bus.y >= Y_LO) && (bus.y < Y_HI);
    cell_edge_s  = in_field_s && ((subx_d == '0) || (suby_d == '0));
    board_addr_d = board_addr_q;
    if (in_field_s) begin
      board_addr_d = row_base_d + BOARD_ADDR_W'(col_d);
    end else begin
      board_addr_d = board_addr_q;
    end
  end

  // Piece inputs are sampled only at the vsync falling edge so a frame never tears.
  always_comb begin
    vsync_fall_s = vsync_prev_q && !bus.vsync_in;
    piece_d      = piece_q;
    if (vsync_fall_s) begin
      piece_d.col   = bus.piece_col;
      piece_d.row   = bus.piece_row;
      piece_d.mask  = bus.piece_mask;
      piece_d.ptype = bus.piece_type;
    end else begin
      piece_d = piece_q;
    end
  end

  // Stage 1: col_q/row_q now describe the pixel whose RAM data is arriving.
  always_comb begin
    hit_s     = piece_hit(7'(row_q), 7'(col_q), piece_q);
    blktype_d = NOBLOCK;
    if (!dl_taps_s[0][DL_IF]) begin
      blktype_d = NOBLOCK;
    end else if (hit_s) begin
      blktype_d = piece_q.ptype;
    end else begin
      blktype_d = bus.board_data;
    end
  end

  // All scan state advances on pix_en only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      subx_q       <= '0;
      suby_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      row_base_q   <= '0;
      board_addr_q <= '0;
      vsync_prev_q <= 1'b1;
      piece_q      <= '0;
      blktype_q    <= '0;
    end else if (bus.pix_en) begin
      subx_q       <= subx_d;
      suby_q       <= suby_d;
      col_q        <= col_d;
      row_q        <= row_d;
      row_base_q   <= row_base_d;
      board_addr_q <= board_addr_d;
      vsync_prev_q <= bus.vsync_in;
      piece_q      <= piece_d;
      blktype_q    <= blktype_d;
    end
  end

  assign dl_in_s = {bus.active_in, bus.hsync_in, bus.vsync_in, in_field_s, cell_edge_s};

  pix_delay #(
    .N         (2),
    .W         (DL_W),
    .RESET_VAL (DL_RST)
  ) u_pix_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (bus.pix_en),
    .din_i  (dl_in_s),
    .taps_o (dl_taps_s)
  );

  assign unused_taps_s = ^{dl_taps_s[0][DL_ACT], dl_taps_s[0][DL_HS],
                           dl_taps_s[0][DL_VS], dl_taps_s[0][DL_CE]};

  assign bus.board_addr = board_addr_q;
  assign bus.blktype    = blktype_q;
  assign bus.in_field   = dl_taps_s[1][DL_IF];
  assign bus.cell_edge  = dl_taps_s[1][DL_CE];
  assign bus.active_out = dl_taps_s[1][DL_ACT];
  assign bus.hsync_out  = dl_taps_s[1][DL_HS];
  assign bus.vsync_out  = dl_taps_s[1][DL_VS];

endmodule

// File: tb/tb_playfield_scanner.sv
// Raster-scan bench for playfield_scanner: pixels are mapped to cells with plain
// division, overlaid with the frame's piece, and compared two enables later.
module tb_playfield_scanner;
  import tetris_pkg::*;

  typedef struct {
    int x;
    int y;
    int fr;
    bit inf;
    bit cedge;
    bit act;
    bit hs;
    bit vs;
    bit sync_ok;
    int blk;
    int addr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int          checks;
  int          errors;
  logic [2:0]  ram [0:255];
  exp_t        pipe_q[$];
  exp_t        cur;
  exp_t        lastcap;
  bit          cur_valid;
  bit          lastcap_valid;
  bit          synced;
  bit          prev_vs;
  bit          stall_mode;
  int          sh_row, sh_col, sh_type;
  logic [15:0] sh_mask;
  int          frame_no;
  int          rand_line [3];

  playfield_scanner_if bus ();

  playfield_scanner dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.board_data = ram[bus.board_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s pixel(%0d,%0d) frame %0d: got %0d, expected %0d",
               name, cur.x, cur.y, cur.fr, got, want);
    end
  endtask

  function automatic exp_t model_pix(input int x, input int y);
    exp_t e;
    int row, col, r, c;
    e.x = x; e.y = y; e.fr = frame_no;
    e.act = (x < 640) && (y < 480);
    e.hs  = !((x >= 656) && (x < 752));
    e.vs  = !((y == 490) || (y == 491));
    e.inf = (x >= 220) && (x < 420) && (y >= 40) && (y < 440);
    row = (y - 40) / 20;
    col = (x - 220) / 20;
    e.cedge = e.inf && ((((x - 220) % 20) == 0) || (((y - 40) % 20) == 0));
    e.addr = row * 10 + col;
    e.blk = 0;
    e.sync_ok = 1'b0;
    if (e.inf) begin
      r = row - sh_row;
      c = col - sh_col;
      if (r >= 0 && r <= 3 && c >= 0 && c <= 3 && sh_mask[r*4+c]) e.blk = sh_type;
      else e.blk = int'(ram[e.addr]);
    end
    return e;
  endfunction

  // Reference model: capture every enabled pixel; outputs lag by one more enable.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        pipe_q.delete();
        cur_valid = 1'b0; lastcap_valid = 1'b0; synced = 1'b0; prev_vs = 1'b1;
        sh_row = 0; sh_col = 0; sh_type = 0; sh_mask = 16'h0000;
      end else if (bus.pix_en) begin
        if (prev_vs && !bus.vsync_in) begin
          sh_row  = int'($signed(bus.piece_row));
          sh_col  = int'($signed(bus.piece_col));
          sh_mask = bus.piece_mask;
          sh_type = int'(bus.piece_type);
        end
        prev_vs = bus.vsync_in;
        if (bus.x == 10'd0 && bus.y == 10'd40) synced = 1'b1;
        e = model_pix(int'(bus.x), int'(bus.y));
        e.sync_ok = synced;
        pipe_q.push_back(e);
        lastcap = e;
        lastcap_valid = 1'b1;
        if (pipe_q.size() == 2) begin
          cur = pipe_q.pop_front();
          cur_valid = 1'b1;
        end
      end
    end
  end

  // Compare on the falling edge, away from register updates.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_hsync", int'(bus.hsync_out), 1);
        chk("rst_vsync", int'(bus.vsync_out), 1);
        chk("rst_blktype", int'(bus.blktype), 0);
        chk("rst_addr", int'(bus.board_addr), 0);
        chk("rst_active", int'(bus.active_out), 0);
        chk("rst_infield", int'(bus.in_field), 0);
      end else if (cur_valid) begin
        chk("active_out", int'(bus.active_out), int'(cur.act));
        chk("hsync_out", int'(bus.hsync_out), int'(cur.hs));
        chk("vsync_out", int'(bus.vsync_out), int'(cur.vs));
        chk("in_field", int'(bus.in_field), int'(cur.inf));
        if (cur.sync_ok) begin
          chk("blktype", int'(bus.blktype), cur.blk);
          chk("cell_edge", int'(bus.cell_edge), int'(cur.cedge));
          if (cur.fr == 0 && cur.x == 220 && cur.y == 40) begin
            chk("preload_blk", int'(bus.blktype), 3);
            chk("preload_edge", int'(bus.cell_edge), 1);
            chk("preload_inf", int'(bus.in_field), 1);
          end
          if (cur.fr == 0 && cur.x == 239 && cur.y == 59) chk("inner_edge", int'(bus.cell_edge), 0);
          if (cur.fr == 0 && cur.x == 420 && cur.y == 439) begin
            chk("right_inf", int'(bus.in_field), 0);
            chk("right_blk", int'(bus.blktype), 0);
          end
          if (cur.fr == 1 && cur.x == 300 && cur.y == 40) chk("ovl_r0c4", int'(bus.blktype), 5);
          if (cur.fr == 1 && cur.x == 280 && cur.y == 40) chk("ovl_r0c3", int'(bus.blktype), 6);
          if (cur.fr == 1 && cur.x == 320 && cur.y == 60) chk("ovl_r1c5", int'(bus.blktype), 5);
          if (cur.fr == 2 && cur.x == 230 && cur.y == 350) chk("tear_old", int'(bus.blktype), 2);
          if (cur.fr == 3 && cur.x == 230 && cur.y == 350) chk("tear_new", int'(bus.blktype), 7);
        end
        if (lastcap_valid && lastcap.sync_ok && lastcap.inf) begin
          chk("board_addr", int'(bus.board_addr), lastcap.addr);
          if (lastcap.fr == 0 && lastcap.x == 419 && lastcap.y == 439)
            chk("addr_corner", int'(bus.board_addr), 199);
        end
      end
    end
  end

  task automatic put(input int x, input int y);
    if (stall_mode) begin
      bus.pix_en = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    bus.x         = 10'(x);
    bus.y         = 10'(y);
    bus.active_in = (x < 640) && (y < 480);
    bus.hsync_in  = !((x >= 656) && (x < 752));
    bus.vsync_in  = !((y == 490) || (y == 491));
    bus.pix_en    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.pix_en = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_piece(input int r, input int c, input logic [15:0] m, input int t);
    bus.piece_row  = 6'(r);
    bus.piece_col  = 5'(c);
    bus.piece_mask = m;
    bus.piece_type = 3'(t);
  endtask

  task automatic pick_lines();
    for (int i = 0; i < 3; i++) rand_line[i] = int'($urandom_range(40, 439));
  endtask

  task automatic rand_ram();
    for (int i = 0; i < 256; i++) ram[i] = 3'($urandom);
  endtask

  function automatic bit is_full(input int y);
    bit f;
    f = (y == 40) || (y == 59) || (y == 60) || (y == 350) || (y == 439);
    for (int i = 0; i < 3; i++) if (rand_line[i] == y) f = 1'b1;
    return f;
  endfunction

  task automatic run_frame(input int fr);
    frame_no = fr;
    put(0, 490);
    put(100, 490);
    put(0, 491);
    for (int y = 0; y < 40; y++) put(0, y);
    for (int y = 40; y < 440; y++) begin
      if (fr == 2 && y == 200) set_piece(15, 0, 16'h0001, 7);
      if (fr == 4 && y == 250) do_reset();
      put(0, y);
      if (is_full(y)) begin
        for (int x = 210; x <= 430; x++) put(x, y);
      end else begin
        put(700, y);
      end
    end
    put(0, 440);
    put(300, 440);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    stall_mode = 1'b0;
    frame_no = 0;
    bus.pix_en = 1'b0;
    bus.x = 10'd0;
    bus.y = 10'd0;
    bus.active_in = 1'b0;
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    set_piece(0, 0, 16'h0000, 0);
    for (int i = 0; i < 256; i++) ram[i] = 3'd0;
    ram[0] = 3'd3;
    for (int i = 0; i < 3; i++) rand_line[i] = 40;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_frame(0);

    ram[3] = 3'd6;
    set_piece(-1, 3, 16'h0660, 5);
    pick_lines();
    run_frame(1);

    rand_ram();
    ram[150] = 3'd2;
    set_piece(0, 0, 16'h0000, 0);
    pick_lines();
    run_frame(2);
    run_frame(3);

    stall_mode = 1'b1;
    for (int fr = 4; fr < 7; fr++) begin
      rand_ram();
      pick_lines();
      set_piece((rand_line[0] - 40) / 20 - int'($urandom_range(0, 3)),
                int'($urandom_range(0, 12)) - 3, 16'($urandom), int'($urandom_range(1, 7)));
      run_frame(fr);
    end

    put(0, 441);
    put(0, 442);
    bus.pix_en = 1'b0;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
